// File: rtl/sumador_pkg.sv
// Shared operation codes for the add/subtract/accumulate datapath.
package sumador_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

endpackage

// File: rtl/sumador_alu.sv
// Combinational core: computes the result, overflow flag and accumulator update for one operation.
module sumador_alu
  import sumador_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int SAT   = 0
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   acc_q,
  output logic [WIDTH:0]   res,
  output logic             ovf,
  output logic [WIDTH:0]   acc_nxt,
  output logic             acc_we
);

  logic [WIDTH+1:0] acc_sum;

  // One guard bit above the accumulator exposes the carry out of the accumulate.
  assign acc_sum = {1'b0, acc_q} + {2'b00, a};

  always_comb begin
    res     = '0;
    ovf     = 1'b0;
    acc_nxt = acc_q;
    acc_we  = 1'b0;
    case (mode)
      MODE_ADD: begin
        res = {1'b0, a} + {1'b0, b};
      end
      MODE_SUB: begin
        res = {1'b0, a} - {1'b0, b};
        ovf = (a < b);
      end
      MODE_ACC: begin
        ovf     = acc_sum[WIDTH+1];
        acc_nxt = ((SAT != 0) && acc_sum[WIDTH+1]) ? '1 : acc_sum[WIDTH:0];
        res     = acc_nxt;
        acc_we  = 1'b1;
      end
      MODE_CLR: begin
        acc_nxt = '0;
        acc_we  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sumador_acc_pipe.sv
// Add/subtract/accumulate unit with valid/ready on both sides and a single registered output slot.
module sumador_acc_pipe #(
  parameter int WIDTH = 5,
  parameter int SAT   = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   c,
  output logic             ovf,
  output logic [WIDTH:0]   acc_q,
  output logic [CNT_W-1:0] res_cnt
);

  logic             valid_q, valid_d;
  logic [WIDTH:0]   c_q, c_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   accum_q, accum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             deliver;
  logic [WIDTH:0]   alu_res;
  logic             alu_ovf;
  logic [WIDTH:0]   alu_acc_nxt;
  logic             alu_acc_we;

  sumador_alu #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_alu (
    .mode    (mode),
    .a       (a),
    .b       (b),
    .acc_q   (accum_q),
    .res     (alu_res),
    .ovf     (alu_ovf),
    .acc_nxt (alu_acc_nxt),
    .acc_we  (alu_acc_we)
  );

  // The slot can refill in the same cycle it drains, giving full throughput.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign deliver  = valid_q && out_ready;

  always_comb begin
    valid_d = valid_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    accum_d = accum_q;
    cnt_d   = cnt_q;
    if (deliver) begin
      cnt_d   = cnt_q + 1'b1;
      valid_d = 1'b0;
    end
    if (accept) begin
      valid_d = 1'b1;
      c_d     = alu_res;
      ovf_d   = alu_ovf;
      if (alu_acc_we) begin
        accum_d = alu_acc_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      accum_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      accum_q <= accum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign c         = c_q;
  assign ovf       = ovf_q;
  assign acc_q     = accum_q;
  assign res_cnt   = cnt_q;

endmodule
